// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use stall detection and D-cache miss freeze control.
// Optional saturating perf counters are compiled in with `define FWD_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int RA_W    = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_SRC*RA_W-1:0] i_rs_ID,
  input  logic [NUM_SRC*RA_W-1:0] i_rs_EX,
  input  logic [RA_W-1:0]         i_rd_EX,
  input  logic                    i_memread_EX,
  input  logic                    i_regwrite_EX,
  input  logic [RA_W-1:0]         i_write_reg_MEM,
  input  logic                    i_regwrite_MEM,
  input  logic                    i_wb_MEM,
  input  logic                    i_slt_MEM,
  input  logic                    i_jump_MEM,
  input  logic                    i_memtoreg_MEM,
  input  logic [RA_W-1:0]         i_write_reg_WB,
  input  logic                    i_regwrite_WB,
  input  logic [DATA_W-1:0]       i_wb_data_WB,
  input  logic                    i_dmem_stall,
  output logic [NUM_SRC*3-1:0]    o_fwd,
  output logic [DATA_W-1:0]       o_hold_data,
  output logic                    o_stall_id,
  output logic                    o_bubble_ex,
`ifdef FWD_PERF_CNT_EN
  output logic                    o_freeze,
  output logic [CNT_W-1:0]        o_ldu_cnt,
  output logic [CNT_W-1:0]        o_frz_cnt
`else
  output logic                    o_freeze
`endif
);

  if (NUM_SRC < 2 || NUM_SRC > 3 || CNT_W < 1) begin : g_bad_params
    $error("fwd_hazard_unit: unsupported parameter combination");
  end

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_e;

  state_e            state;
  state_e            state_nxt;
  logic              hold_capture;
  logic              hold_vld;
  logic [RA_W-1:0]   hold_rd;
  logic [DATA_W-1:0] hold_data;
  logic [2:0]        mem_kind_sel;
  logic              mem_fwd_ok;
  logic              wb_fwd_ok;
  logic              ldu_hit;
  logic              ldu_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (i_dmem_stall)  state_nxt = FROZEN;
      FROZEN:  if (!i_dmem_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // The WB result is only captured on entry to a freeze; later frozen cycles carry bubbles.
  always_comb begin
    o_freeze     = i_dmem_stall;
    hold_capture = (state == RUN) && i_dmem_stall;
  end

  // The hold entry survives the release cycle so the frozen EX instruction can still consume it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_vld  <= 1'b0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else if (hold_capture) begin
      hold_vld  <= i_regwrite_WB && (i_write_reg_WB != '0);
      hold_rd   <= i_write_reg_WB;
      hold_data <= i_wb_data_WB;
    end else if (!i_dmem_stall) begin
      hold_vld  <= 1'b0;
    end
  end

  assign o_hold_data = hold_data;

  // Only the four single-kind MEM results are forwardable; anything else defers to WB/hold.
  always_comb begin
    case ({i_wb_MEM, i_slt_MEM, i_jump_MEM, i_memtoreg_MEM})
      4'b0000: mem_kind_sel = 3'd1;
      4'b0100: mem_kind_sel = 3'd2;
      4'b1000: mem_kind_sel = 3'd3;
      4'b0010: mem_kind_sel = 3'd4;
      default: mem_kind_sel = 3'd0;
    endcase
  end

  assign mem_fwd_ok = i_regwrite_MEM && (i_write_reg_MEM != '0) && (mem_kind_sel != 3'd0);
  assign wb_fwd_ok  = i_regwrite_WB && (i_write_reg_WB != '0);

  always_comb begin
    o_fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [RA_W-1:0] rs;
      rs = i_rs_EX[k*RA_W +: RA_W];
      if (rs != '0) begin
        if (mem_fwd_ok && (rs == i_write_reg_MEM))  o_fwd[k*3 +: 3] = mem_kind_sel;
        else if (wb_fwd_ok && (rs == i_write_reg_WB)) o_fwd[k*3 +: 3] = 3'd5;
        else if (hold_vld && (rs == hold_rd))         o_fwd[k*3 +: 3] = 3'd6;
      end
    end
  end

  always_comb begin
    ldu_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_rs_ID[k*RA_W +: RA_W] == i_rd_EX) ldu_hit = 1'b1;
    end
  end

  // A freeze already holds the front end, so the load-use stall waits until release.
  assign ldu_stall   = i_memread_EX && i_regwrite_EX && (i_rd_EX != '0) && ldu_hit && !o_freeze;
  assign o_stall_id  = ldu_stall;
  assign o_bubble_ex = ldu_stall;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] ldu_cnt;
  logic [CNT_W-1:0] frz_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ldu_cnt <= '0;
      frz_cnt <= '0;
    end else begin
      if (o_stall_id && (ldu_cnt != '1)) ldu_cnt <= ldu_cnt + CNT_W'(1);
      if (o_freeze && (frz_cnt != '1))   frz_cnt <= frz_cnt + CNT_W'(1);
    end
  end

  assign o_ldu_cnt = ldu_cnt;
  assign o_frz_cnt = frz_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (3 sources); perf counters checked when
// FWD_PERF_CNT_EN is defined.
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 3;
  localparam int RA_W    = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [NUM_SRC*RA_W-1:0] i_rs_ID;
  logic [NUM_SRC*RA_W-1:0] i_rs_EX;
  logic [RA_W-1:0]         i_rd_EX;
  logic                    i_memread_EX;
  logic                    i_regwrite_EX;
  logic [RA_W-1:0]         i_write_reg_MEM;
  logic                    i_regwrite_MEM;
  logic                    i_wb_MEM;
  logic                    i_slt_MEM;
  logic                    i_jump_MEM;
  logic                    i_memtoreg_MEM;
  logic [RA_W-1:0]         i_write_reg_WB;
  logic                    i_regwrite_WB;
  logic [DATA_W-1:0]       i_wb_data_WB;
  logic                    i_dmem_stall;
  logic [NUM_SRC*3-1:0]    o_fwd;
  logic [DATA_W-1:0]       o_hold_data;
  logic                    o_stall_id;
  logic                    o_bubble_ex;
  logic                    o_freeze;
`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0]        o_ldu_cnt;
  logic [CNT_W-1:0]        o_frz_cnt;
`endif

  int n_checks   = 0;
  int n_failures = 0;

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .RA_W(RA_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs_ID(i_rs_ID), .i_rs_EX(i_rs_EX),
    .i_rd_EX(i_rd_EX), .i_memread_EX(i_memread_EX), .i_regwrite_EX(i_regwrite_EX),
    .i_write_reg_MEM(i_write_reg_MEM), .i_regwrite_MEM(i_regwrite_MEM),
    .i_wb_MEM(i_wb_MEM), .i_slt_MEM(i_slt_MEM), .i_jump_MEM(i_jump_MEM),
    .i_memtoreg_MEM(i_memtoreg_MEM),
    .i_write_reg_WB(i_write_reg_WB), .i_regwrite_WB(i_regwrite_WB),
    .i_wb_data_WB(i_wb_data_WB), .i_dmem_stall(i_dmem_stall),
    .o_fwd(o_fwd), .o_hold_data(o_hold_data),
    .o_stall_id(o_stall_id), .o_bubble_ex(o_bubble_ex),
`ifdef FWD_PERF_CNT_EN
    .o_freeze(o_freeze), .o_ldu_cnt(o_ldu_cnt), .o_frz_cnt(o_frz_cnt)
`else
    .o_freeze(o_freeze)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [14:0] rs3(input int r2, input int r1, input int r0);
    return {5'(r2), 5'(r1), 5'(r0)};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's MEM/WB/cache inputs, then lets combinational outputs settle.
  task automatic apply_stimulus(input logic [14:0] rs_ex, input logic [14:0] rs_id,
                                input int mem_rd, input logic mem_rw, input logic [3:0] flags,
                                input int wb_rd, input logic wb_rw, input logic [31:0] wb_data,
                                input logic stall);
    i_rs_EX         = rs_ex;
    i_rs_ID         = rs_id;
    i_write_reg_MEM = 5'(mem_rd);
    i_regwrite_MEM  = mem_rw;
    {i_wb_MEM, i_slt_MEM, i_jump_MEM, i_memtoreg_MEM} = flags;
    i_write_reg_WB  = 5'(wb_rd);
    i_regwrite_WB   = wb_rw;
    i_wb_data_WB    = wb_data;
    i_dmem_stall    = stall;
    #2;
  endtask

  task automatic set_load(input logic ld, input int rd);
    i_memread_EX  = ld;
    i_regwrite_EX = ld;
    i_rd_EX       = 5'(rd);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    set_load(1'b0, 0);
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("rst_freeze", 32'(o_freeze), 32'd0);
    check_output("rst_stall", 32'(o_stall_id), 32'd0);
    check_output("rst_bubble", 32'(o_bubble_ex), 32'd0);
    check_output("rst_fwd", 32'(o_fwd), 32'd0);
    check_output("rst_hold", o_hold_data, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // MEM result kinds on src0, with WB also matching as the lower-priority fallback
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b0000, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_alu", 32'(o_fwd[2:0]), 32'd1);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b0100, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_slt", 32'(o_fwd[2:0]), 32'd2);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b1000, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_wbsp", 32'(o_fwd[2:0]), 32'd3);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b0010, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_jump", 32'(o_fwd[2:0]), 32'd4);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b0001, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_load_to_wb", 32'(o_fwd[2:0]), 32'd5);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b1, 4'b1100, 5, 1'b1, 32'h55, 1'b0);
    check_output("mem_multi_to_wb", 32'(o_fwd[2:0]), 32'd5);
    apply_stimulus(rs3(0,0,5), '0, 5, 1'b0, 4'b0000, 6, 1'b1, 32'h55, 1'b0);
    check_output("mem_no_regwrite", 32'(o_fwd[2:0]), 32'd0);
    tick();

    apply_stimulus(rs3(0,0,0), '0, 0, 1'b1, 4'b0000, 0, 1'b1, 32'h1, 1'b0);
    check_output("x0_src", 32'(o_fwd), 32'd0);
    apply_stimulus(rs3(5,7,0), '0, 5, 1'b1, 4'b0000, 7, 1'b1, 32'h1, 1'b0);
    check_output("three_src", 32'(o_fwd), {23'd0, 3'd1, 3'd5, 3'd0});
    tick();

    // Load-use: one stall cycle, then the load result comes from WB
    set_load(1'b1, 9);
    apply_stimulus('0, rs3(0,9,0), 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("ldu_stall", 32'(o_stall_id), 32'd1);
    check_output("ldu_bubble", 32'(o_bubble_ex), 32'd1);
    tick();
    set_load(1'b0, 0);
    apply_stimulus(rs3(0,9,0), '0, 0, 1'b0, 4'b0000, 9, 1'b1, 32'h99, 1'b0);
    check_output("ldu_after_stall", 32'(o_stall_id), 32'd0);
    check_output("ldu_after_fwd", 32'(o_fwd[5:3]), 32'd5);
    set_load(1'b1, 0);
    apply_stimulus('0, rs3(0,0,0), 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("ldu_rd_x0", 32'(o_stall_id), 32'd0);
    set_load(1'b0, 0);
    tick();

    // Freeze: capture WB rd 12, forward from hold through the release cycle only
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 12, 1'b1, 32'hDEADBEEF, 1'b1);
    check_output("frz1_freeze", 32'(o_freeze), 32'd1);
    check_output("frz1_fwd", 32'(o_fwd[2:0]), 32'd5);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h12345678, 1'b1);
    check_output("frz2_freeze", 32'(o_freeze), 32'd1);
    check_output("frz2_fwd", 32'(o_fwd[2:0]), 32'd6);
    check_output("frz2_hold", o_hold_data, 32'hDEADBEEF);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 12, 1'b1, 32'h12345678, 1'b1);
    check_output("frz3_freeze", 32'(o_freeze), 32'd1);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("rel_freeze", 32'(o_freeze), 32'd0);
    check_output("rel_fwd", 32'(o_fwd[2:0]), 32'd6);
    check_output("rel_hold_kept", o_hold_data, 32'hDEADBEEF);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("post_rel_fwd", 32'(o_fwd[2:0]), 32'd0);
    tick();

    // Load-use hazard masked while frozen, visible once released
    set_load(1'b1, 9);
    apply_stimulus('0, rs3(0,9,0), 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
    check_output("frz_ldu_stall", 32'(o_stall_id), 32'd0);
    check_output("frz_ldu_bubble", 32'(o_bubble_ex), 32'd0);
    tick();
    apply_stimulus('0, rs3(0,9,0), 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("rel_ldu_stall", 32'(o_stall_id), 32'd1);
    tick();
    set_load(1'b0, 0);

    // Back-to-back freeze: restall in the first RUN cycle recaptures
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 12, 1'b1, 32'hAAAA0001, 1'b1);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("b2b_rel_fwd", 32'(o_fwd[2:0]), 32'd6);
    tick();
    apply_stimulus(rs3(0,13,12), '0, 0, 1'b0, 4'b0000, 13, 1'b1, 32'hBBBB0002, 1'b1);
    check_output("b2b_old_cleared", 32'(o_fwd[2:0]), 32'd0);
    tick();
    apply_stimulus(rs3(0,13,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
    check_output("b2b_hold", o_hold_data, 32'hBBBB0002);
    check_output("b2b_fwd", 32'(o_fwd[5:3]), 32'd6);
    tick();
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    tick();

    // Asynchronous reset in the middle of a freeze
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 12, 1'b1, 32'hC0FFEE00, 1'b1);
    tick();
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
    check_output("pre_rst_fwd", 32'(o_fwd[2:0]), 32'd6);
    #1;
    i_rst = 1'b1;
    apply_stimulus(rs3(0,0,12), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("arst_freeze", 32'(o_freeze), 32'd0);
    check_output("arst_stall", 32'(o_stall_id), 32'd0);
    check_output("arst_fwd", 32'(o_fwd), 32'd0);
    check_output("arst_hold", o_hold_data, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    apply_stimulus(rs3(0,0,3), '0, 0, 1'b0, 4'b0000, 3, 1'b1, 32'h0000CAFE, 1'b1);
    tick();
    apply_stimulus(rs3(0,0,3), '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
    check_output("post_rst_capture", o_hold_data, 32'h0000CAFE);
    check_output("post_rst_fwd", 32'(o_fwd[2:0]), 32'd6);
    tick();
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    tick();

`ifdef FWD_PERF_CNT_EN
    #1;
    i_rst = 1'b1;
    #2;
    check_output("cnt_rst_frz", 32'(o_frz_cnt), 32'd0);
    check_output("cnt_rst_ldu", 32'(o_ldu_cnt), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    set_load(1'b1, 9);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus('0, rs3(0,9,0), 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    set_load(1'b0, 0);
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    check_output("cnt_frz4", 32'(o_frz_cnt), 32'd4);
    check_output("cnt_ldu2", 32'(o_ldu_cnt), 32'd2);
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 65540; i++) tick();
    check_output("cnt_frz_sat", 32'(o_frz_cnt), 32'h0000FFFF);
    apply_stimulus('0, '0, 0, 1'b0, 4'b0000, 0, 1'b0, 32'h0, 1'b0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
